// File: rtl/ram_pipelined_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_pipelined_if                                             |
// | Description : Request/response bundle between the datapath control unit   |
// |               and ram_pipelined. parity_err exists only with RAM_PARITY_EN.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   D;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    init_req;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   Q;
  logic                    rvalid;
  logic                    addr_err;
  logic                    busy_init;
`ifdef RAM_PARITY_EN
  logic                    parity_err;

  modport master (
    output req, we, address, D, be, init_req,
    input  ready, Q, rvalid, addr_err, busy_init, parity_err
  );
  modport slave (
    input  req, we, address, D, be, init_req,
    output ready, Q, rvalid, addr_err, busy_init, parity_err
  );
`else
  modport master (
    output req, we, address, D, be, init_req,
    input  ready, Q, rvalid, addr_err, busy_init
  );
  modport slave (
    input  req, we, address, D, be, init_req,
    output ready, Q, rvalid, addr_err, busy_init
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ram_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_pipelined                                                |
// | Description : Single-port byte-writable word RAM with a valid-qualified    |
// |               read pipeline, range check and zero-fill sweep.              |
// |               Optional macro RAM_PARITY_EN adds per-word even parity.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ram_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic           clock,
  input  logic           clear_n,
  ram_pipelined_if.slave bus
);

  localparam int c_LANES = DATA_WIDTH / 8;
  localparam int c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] c_ST_INIT  = 1'b0;
  localparam logic [0:0] c_ST_IDLE  = 1'b1;
  localparam logic [0:0] c_ST_RESET = (INIT_ZERO != 0) ? c_ST_INIT : c_ST_IDLE;

  localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [0:0]            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  w_ready, w_busy;
  logic                  w_in_range, w_acc, w_wr, w_rd, w_sweep;
  logic [c_IW-1:0]       w_idx, w_cnt_idx;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_pd  [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pv, r_pok;
  logic [DATA_WIDTH-1:0]   r_q;
  logic                    r_rvalid, r_addr_err;

  // Upper address bits take part in the range check, so aliases are rejected.
  assign w_in_range = {1'b0, bus.address} < c_DEPTH;
  assign w_acc      = bus.req & w_ready;
  assign w_wr       = w_acc & bus.we & w_in_range;
  assign w_rd       = w_acc & ~bus.we;
  assign w_sweep    = (r_state == c_ST_INIT);
  assign w_idx      = bus.address[c_IW-1:0];
  assign w_cnt_idx  = r_cnt[c_IW-1:0];

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= c_ST_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_INIT: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = c_ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        if (bus.init_req) begin
          w_state_nxt = c_ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_ready = (r_state == c_ST_IDLE);
    w_busy  = (r_state == c_ST_INIT);
  end

  // Storage and read data path carry no reset; validity lives in r_pv/r_pok.
  always_ff @(posedge clock) begin
    if (w_sweep) begin
      r_mem[w_cnt_idx] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < c_LANES; i++) begin
        if (bus.be[i]) r_mem[w_idx][8*i +: 8] <= bus.D[8*i +: 8];
      end
    end
    r_pd[0] <= r_mem[w_idx];
    for (int i = 1; i < READ_LATENCY; i++) r_pd[i] <= r_pd[i-1];
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_pv       <= '0;
      r_pok      <= '0;
      r_q        <= '0;
      r_rvalid   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_pv[0]  <= w_rd;
      r_pok[0] <= w_in_range;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pok[i] <= r_pok[i-1];
      end
      r_rvalid <= r_pv[READ_LATENCY-1];
      if (r_pv[READ_LATENCY-1]) r_q <= r_pok[READ_LATENCY-1] ? r_pd[READ_LATENCY-1] : '0;
      r_addr_err <= w_acc & ~w_in_range;
    end
  end

`ifdef RAM_PARITY_EN
  logic                  r_par [DEPTH];
  logic                  r_pp  [READ_LATENCY];
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  r_parity_err;

  // Parity covers the word as it will look after the byte-lane merge.
  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < c_LANES; i++) begin
      if (bus.be[i]) w_merged[8*i +: 8] = bus.D[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (w_sweep) begin
      r_par[w_cnt_idx] <= 1'b0;
    end else if (w_wr) begin
      r_par[w_idx] <= ^w_merged;
    end
    r_pp[0] <= r_par[w_idx];
    for (int i = 1; i < READ_LATENCY; i++) r_pp[i] <= r_pp[i-1];
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= r_pv[READ_LATENCY-1] & r_pok[READ_LATENCY-1]
                      & (^{r_pd[READ_LATENCY-1], r_pp[READ_LATENCY-1]});
    end
  end

  assign bus.parity_err = r_parity_err;
`endif

  assign bus.ready     = w_ready;
  assign bus.busy_init = w_busy;
  assign bus.Q         = r_q;
  assign bus.rvalid    = r_rvalid;
  assign bus.addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_pipelined                                             |
// | Description : Directed bench for ram_pipelined over three configurations.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ram_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  int   total = 0;
  int   bad   = 0;

  ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus_a ();
  ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) bus_b ();
  ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_c ();

  ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(512), .READ_LATENCY(1), .INIT_ZERO(1))
    u_a (.clock(clk), .clear_n(rst_a), .bus(bus_a));
  ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(400), .READ_LATENCY(3), .INIT_ZERO(1))
    u_b (.clock(clk), .clear_n(rst_b), .bus(bus_b));
  ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2), .INIT_ZERO(0))
    u_c (.clock(clk), .clear_n(rst_c), .bus(bus_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic w, input logic [8:0] ad, input logic [31:0] d, input logic [3:0] b);
    bus_a.req = r; bus_a.we = w; bus_a.address = ad; bus_a.D = d; bus_a.be = b;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [8:0] ad, input logic [31:0] d, input logic [3:0] b);
    bus_b.req = r; bus_b.we = w; bus_b.address = ad; bus_b.D = d; bus_b.be = b;
  endtask

  task automatic drv_c(input logic r, input logic w, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] b);
    bus_c.req = r; bus_c.we = w; bus_c.address = ad; bus_c.D = d; bus_c.be = b;
  endtask

  task automatic test_reset();
    int  done_a = 0;
    int  done_b = 0;
    bit  rdy_bad = 1'b0;
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0); drv_c(0, 0, 0, 0, 0);
    bus_a.init_req = 0; bus_b.init_req = 0; bus_c.init_req = 0;
    repeat (3) tick();
    total++; if (bus_a.busy_init !== 1'b1) begin bad++; $display("FAIL reset_a_busy: got %b want 1", bus_a.busy_init); end
    total++; if (bus_a.ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready: got %b want 0", bus_a.ready); end
    total++; if (bus_a.rvalid !== 1'b0) begin bad++; $display("FAIL reset_a_rvalid: got %b want 0", bus_a.rvalid); end
    total++; if (bus_a.Q !== 32'h0) begin bad++; $display("FAIL reset_a_q: got %h want 0", bus_a.Q); end
    total++; if (bus_a.addr_err !== 1'b0) begin bad++; $display("FAIL reset_a_err: got %b want 0", bus_a.addr_err); end
    total++; if (bus_c.ready !== 1'b1) begin bad++; $display("FAIL reset_c_ready: got %b want 1", bus_c.ready); end
    total++; if (bus_c.busy_init !== 1'b0) begin bad++; $display("FAIL reset_c_busy: got %b want 0", bus_c.busy_init); end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      tick();
      if (done_a == 0 && bus_a.busy_init === 1'b0) done_a = n;
      if (done_b == 0 && bus_b.busy_init === 1'b0) done_b = n;
      if (bus_a.ready !== !bus_a.busy_init) rdy_bad = 1'b1;
    end
    total++; if (done_a != 512) begin bad++; $display("FAIL sweep_a_cycles: got %0d want 512", done_a); end
    total++; if (done_b != 400) begin bad++; $display("FAIL sweep_b_cycles: got %0d want 400", done_b); end
    total++; if (rdy_bad !== 1'b0) begin bad++; $display("FAIL sweep_ready_vs_busy: got %b want 0", rdy_bad); end
  endtask

  task automatic test_sweep_read();
    logic [8:0] ad [3];
    ad[0] = 9'd0; ad[1] = 9'd255; ad[2] = 9'd511;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drv_a(1, 0, ad[k], 0, 0); else drv_a(0, 0, 0, 0, 0);
      tick();
      if (k >= 1 && k <= 3) begin
        total++; if (bus_a.rvalid !== 1'b1 || bus_a.Q !== 32'h0) begin bad++;
          $display("FAIL sweep_read_%0d: got rv=%b q=%h want rv=1 q=0", k, bus_a.rvalid, bus_a.Q); end
      end else if (k == 4) begin
        total++; if (bus_a.rvalid !== 1'b0) begin bad++; $display("FAIL sweep_read_end: got rv=%b want 0", bus_a.rvalid); end
      end
    end
  endtask

  task automatic test_byte_write();
    drv_a(1, 1, 9'h010, 32'hDEADBEEF, 4'b1111); tick();
    drv_a(1, 1, 9'h010, 32'h00001122, 4'b0011); tick();
    total++; if (bus_a.rvalid !== 1'b0) begin bad++; $display("FAIL write_no_rvalid: got %b want 0", bus_a.rvalid); end
    drv_a(1, 1, 9'h010, 32'hFFFFFFFF, 4'b0000); tick();
    drv_a(1, 0, 9'h011, 0, 0); tick();
    drv_a(1, 0, 9'h010, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.Q !== 32'h0) begin bad++;
      $display("FAIL bw_read_011: got rv=%b q=%h want rv=1 q=00000000", bus_a.rvalid, bus_a.Q); end
    drv_a(0, 0, 0, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.Q !== 32'hDEAD1122) begin bad++;
      $display("FAIL bw_read_010: got rv=%b q=%h want rv=1 q=dead1122", bus_a.rvalid, bus_a.Q); end
    tick();
    total++; if (bus_a.rvalid !== 1'b0 || bus_a.Q !== 32'hDEAD1122) begin bad++;
      $display("FAIL bw_q_hold: got rv=%b q=%h want rv=0 q=dead1122", bus_a.rvalid, bus_a.Q); end
  endtask

  task automatic test_latency3();
    logic [31:0] ex [3];
    ex[0] = 32'hA; ex[1] = 32'hB; ex[2] = 32'hC;
    for (int k = 0; k < 3; k++) begin drv_b(1, 1, 9'(k + 1), ex[k], 4'hF); tick(); end
    for (int k = 0; k < 7; k++) begin
      if (k < 3) drv_b(1, 0, 9'(k + 1), 0, 0); else drv_b(0, 0, 0, 0, 0);
      tick();
      if (k >= 3 && k <= 5) begin
        total++; if (bus_b.rvalid !== 1'b1 || bus_b.Q !== ex[k-3]) begin bad++;
          $display("FAIL lat3_data_%0d: got rv=%b q=%h want rv=1 q=%h", k, bus_b.rvalid, bus_b.Q, ex[k-3]); end
      end else begin
        total++; if (bus_b.rvalid !== 1'b0) begin bad++; $display("FAIL lat3_idle_%0d: got rv=%b want 0", k, bus_b.rvalid); end
      end
    end
  endtask

  task automatic test_out_of_range();
    drv_b(1, 1, 9'h190, 32'hFFFFFFFF, 4'hF); tick();
    total++; if (bus_b.addr_err !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", bus_b.addr_err); end
    drv_b(1, 1, 9'h18F, 32'h00000077, 4'hF); tick();
    total++; if (bus_b.addr_err !== 1'b0) begin bad++; $display("FAIL oor_last_ok: got %b want 0", bus_b.addr_err); end
    drv_b(0, 0, 0, 0, 0); tick();
    drv_b(1, 0, 9'h190, 0, 0); tick();
    total++; if (bus_b.addr_err !== 1'b1) begin bad++; $display("FAIL oor_rd_err: got %b want 1", bus_b.addr_err); end
    drv_b(0, 0, 0, 0, 0); tick();
    total++; if (bus_b.addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse: got %b want 0", bus_b.addr_err); end
    tick();
    total++; if (bus_b.rvalid !== 1'b0) begin bad++; $display("FAIL oor_rd_early: got rv=%b want 0", bus_b.rvalid); end
    tick();
    total++; if (bus_b.rvalid !== 1'b1 || bus_b.Q !== 32'h0) begin bad++;
      $display("FAIL oor_rd_data: got rv=%b q=%h want rv=1 q=0", bus_b.rvalid, bus_b.Q); end
    drv_b(1, 0, 9'h18F, 0, 0); tick();
    drv_b(0, 0, 0, 0, 0); repeat (3) tick();
    total++; if (bus_b.rvalid !== 1'b1 || bus_b.Q !== 32'h77) begin bad++;
      $display("FAIL oor_last_read: got rv=%b q=%h want rv=1 q=77", bus_b.rvalid, bus_b.Q); end
  endtask

  task automatic test_no_init();
    drv_c(1, 1, 5'h03, 32'h11111111, 4'hF); tick();
    drv_c(1, 1, 5'h13, 32'hFFFFFFFF, 4'hF); tick();
    total++; if (bus_c.addr_err !== 1'b1) begin bad++; $display("FAIL c_oor_wr_err: got %b want 1", bus_c.addr_err); end
    drv_c(1, 1, 5'h0F, 32'h0F0F0F0F, 4'hF); tick();
    total++; if (bus_c.addr_err !== 1'b0) begin bad++; $display("FAIL c_last_wr_err: got %b want 0", bus_c.addr_err); end
    drv_c(1, 0, 5'h03, 0, 0); tick();
    drv_c(1, 0, 5'h13, 0, 0); tick();
    total++; if (bus_c.addr_err !== 1'b1) begin bad++; $display("FAIL c_oor_rd_err: got %b want 1", bus_c.addr_err); end
    drv_c(1, 0, 5'h0F, 0, 0); tick();
    total++; if (bus_c.rvalid !== 1'b1 || bus_c.Q !== 32'h11111111) begin bad++;
      $display("FAIL c_alias_kept: got rv=%b q=%h want rv=1 q=11111111", bus_c.rvalid, bus_c.Q); end
    drv_c(0, 0, 0, 0, 0); tick();
    total++; if (bus_c.rvalid !== 1'b1 || bus_c.Q !== 32'h0) begin bad++;
      $display("FAIL c_oor_rd_data: got rv=%b q=%h want rv=1 q=0", bus_c.rvalid, bus_c.Q); end
    tick();
    total++; if (bus_c.rvalid !== 1'b1 || bus_c.Q !== 32'h0F0F0F0F) begin bad++;
      $display("FAIL c_last_read: got rv=%b q=%h want rv=1 q=0f0f0f0f", bus_c.rvalid, bus_c.Q); end
    tick();
    total++; if (bus_c.rvalid !== 1'b0) begin bad++; $display("FAIL c_rvalid_end: got %b want 0", bus_c.rvalid); end
  endtask

  task automatic test_clear_midread();
    bit saw_rv = 1'b0;
    int done = 0;
    drv_b(1, 0, 9'h001, 0, 0); tick();
    drv_b(0, 0, 0, 0, 0); tick();
    rst_b = 1'b0;
    #1;
    total++; if (bus_b.Q !== 32'h0 || bus_b.rvalid !== 1'b0) begin bad++;
      $display("FAIL clr_async: got rv=%b q=%h want rv=0 q=0", bus_b.rvalid, bus_b.Q); end
    tick();
    rst_b = 1'b1;
    total++; if (bus_b.busy_init !== 1'b1) begin bad++; $display("FAIL clr_busy: got %b want 1", bus_b.busy_init); end
    for (int n = 1; n <= 600 && done == 0; n++) begin
      tick();
      if (bus_b.rvalid !== 1'b0) saw_rv = 1'b1;
      if (bus_b.busy_init === 1'b0) done = n;
    end
    total++; if (saw_rv !== 1'b0) begin bad++; $display("FAIL clr_no_rvalid: got %b want 0", saw_rv); end
    total++; if (done != 400) begin bad++; $display("FAIL clr_sweep_cycles: got %0d want 400", done); end
    drv_b(1, 0, 9'h001, 0, 0); tick();
    drv_b(0, 0, 0, 0, 0); repeat (3) tick();
    total++; if (bus_b.rvalid !== 1'b1 || bus_b.Q !== 32'h0) begin bad++;
      $display("FAIL clr_swept: got rv=%b q=%h want rv=1 q=0", bus_b.rvalid, bus_b.Q); end
  endtask

  task automatic test_init_req();
    int n = 0;
    drv_a(1, 1, 9'd7, 32'h55, 4'hF); tick();
    drv_a(1, 0, 9'd7, 0, 0); tick();
    drv_a(0, 0, 0, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.Q !== 32'h55) begin bad++;
      $display("FAIL ireq_pre: got rv=%b q=%h want rv=1 q=55", bus_a.rvalid, bus_a.Q); end
    bus_a.init_req = 1'b1;
    drv_a(1, 1, 9'd9, 32'h66, 4'hF); tick();
    bus_a.init_req = 1'b0;
    drv_a(0, 0, 0, 0, 0);
    total++; if (bus_a.busy_init !== 1'b1 || bus_a.ready !== 1'b0) begin bad++;
      $display("FAIL ireq_enter: got busy=%b ready=%b want busy=1 ready=0", bus_a.busy_init, bus_a.ready); end
    while (bus_a.busy_init === 1'b1 && n < 1000) begin
      bus_a.init_req = (n == 100);
      tick();
      n++;
    end
    bus_a.init_req = 1'b0;
    total++; if (n != 512) begin bad++; $display("FAIL ireq_cycles: got %0d want 512", n); end
    drv_a(1, 0, 9'd7, 0, 0); tick();
    drv_a(1, 0, 9'd9, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.Q !== 32'h0) begin bad++;
      $display("FAIL ireq_addr7: got rv=%b q=%h want rv=1 q=0", bus_a.rvalid, bus_a.Q); end
    drv_a(0, 0, 0, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.Q !== 32'h0) begin bad++;
      $display("FAIL ireq_addr9: got rv=%b q=%h want rv=1 q=0", bus_a.rvalid, bus_a.Q); end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    drv_a(1, 1, 9'h020, 32'h12345678, 4'hF); tick();
    drv_a(1, 0, 9'h020, 0, 0); tick();
    drv_a(0, 0, 0, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.parity_err !== 1'b0) begin bad++;
      $display("FAIL par_clean: got rv=%b perr=%b want rv=1 perr=0", bus_a.rvalid, bus_a.parity_err); end
    u_a.r_mem[32][0] = ~u_a.r_mem[32][0];
    drv_a(1, 0, 9'h020, 0, 0); tick();
    drv_a(0, 0, 0, 0, 0); tick();
    total++; if (bus_a.rvalid !== 1'b1 || bus_a.parity_err !== 1'b1 || bus_a.Q !== 32'h12345679) begin bad++;
      $display("FAIL par_flip: got rv=%b perr=%b q=%h want rv=1 perr=1 q=12345679", bus_a.rvalid, bus_a.parity_err, bus_a.Q); end
    tick();
    total++; if (bus_a.parity_err !== 1'b0) begin bad++; $display("FAIL par_pulse: got %b want 0", bus_a.parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep_read();
    test_byte_write();
    test_latency3();
    test_out_of_range();
    test_no_init();
    test_clear_midread();
    test_init_req();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
